// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-stream 3x3 window generator with STRIDE decimation; define WIN_LAST_EN to add the win_last output
module window_gen_3x3 #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sync_clr,
  input  logic                     pix_valid,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                     win_valid,
  output logic signed [DATA_W-1:0] w0,
  output logic signed [DATA_W-1:0] w1,
  output logic signed [DATA_W-1:0] w2,
  output logic signed [DATA_W-1:0] w3,
  output logic signed [DATA_W-1:0] w4,
  output logic signed [DATA_W-1:0] w5,
  output logic signed [DATA_W-1:0] w6,
  output logic signed [DATA_W-1:0] w7,
  output logic signed [DATA_W-1:0] w8,
  output logic                     frame_done
`ifdef WIN_LAST_EN
  ,
  output logic                     win_last
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [DATA_W-1:0] lb0_q [IMG_W];
  logic signed [DATA_W-1:0] lb1_q [IMG_W];
  logic signed [DATA_W-1:0] sh_q [9];
  logic signed [DATA_W-1:0] sh_d [9];
  logic signed [DATA_W-1:0] out_q [9];
  logic accept, last_col, last_row, emit, win_valid_q, frame_done_q;
  // next counters, emit decision and the window after shifting in the new column
  always_comb begin
    accept   = pix_valid && !sync_clr;
    last_col = col_q == CW'(IMG_W - 1);
    last_row = row_q == RW'(IMG_H - 1);
    col_d    = last_col ? '0 : col_q + CW'(1);
    row_d    = last_col ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    emit     = accept && row_q >= RW'(2) && col_q >= CW'(2) &&
               ((row_q - RW'(2)) % RW'(STRIDE)) == '0 &&
               ((col_q - CW'(2)) % CW'(STRIDE)) == '0;
    for (int i = 0; i < 3; i++) begin
      sh_d[3*i]   = sh_q[3*i+1];
      sh_d[3*i+1] = sh_q[3*i+2];
    end
    sh_d[2] = lb0_q[col_q];
    sh_d[5] = lb1_q[col_q];
    sh_d[8] = pix_data;
  end
  // line buffers age one row per accepted pixel; contents need no reset
  always_ff @(posedge clk)
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix_data;
    end
  // counters, shift window, registered window outputs and strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        sh_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else if (sync_clr) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) sh_q[i] <= '0;
    end else begin
      win_valid_q  <= emit;
      frame_done_q <= accept && last_col && last_row;
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
        sh_q  <= sh_d;
      end
      if (emit) out_q <= sh_d;
    end
`ifdef WIN_LAST_EN
  localparam int LAST_C = 2 + ((IMG_W - 3) / STRIDE) * STRIDE;
  localparam int LAST_R = 2 + ((IMG_H - 3) / STRIDE) * STRIDE;
  logic win_last_q;
  // flag the final window position of a frame alongside its strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) win_last_q <= 1'b0;
    else win_last_q <= emit && row_q == RW'(LAST_R) && col_q == CW'(LAST_C);
  assign win_last = win_last_q;
`endif
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign w0 = out_q[0];
  assign w1 = out_q[1];
  assign w2 = out_q[2];
  assign w3 = out_q[3];
  assign w4 = out_q[4];
  assign w5 = out_q[5];
  assign w6 = out_q[6];
  assign w7 = out_q[7];
  assign w8 = out_q[8];
endmodule
